// File: rtl/mux_nto1_scan_if.sv
// Handshake bundle for the N:1 scanning mux: control, input streams, output stream.
// Ports: enable, mode, sel, in_data/in_valid/in_ready, out_data/out_chan/out_valid/out_ready.
interface mux_nto1_scan_if #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4
);
    localparam int SEL_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    logic                      enable;
    logic                      mode;
    logic [SEL_W-1:0]          sel;
    logic [CHANNELS*WIDTH-1:0] in_data;
    logic [CHANNELS-1:0]       in_valid;
    logic [CHANNELS-1:0]       in_ready;
    logic [WIDTH-1:0]          out_data;
    logic [SEL_W-1:0]          out_chan;
    logic                      out_valid;
    logic                      out_ready;

    // mux side
    modport slave (
        input  enable, mode, sel, in_data, in_valid, out_ready,
        output in_ready, out_data, out_chan, out_valid
    );

    // producer/consumer side
    modport master (
        output enable, mode, sel, in_data, in_valid, out_ready,
        input  in_ready, out_data, out_chan, out_valid
    );
endinterface

// File: rtl/mux_nto1_scan.sv
// Registered N:1 stream mux with manual select or round-robin scan with dwell.
// Ports: clk, reset (async, active-high), bus (slave view of mux_nto1_scan_if).
module mux_nto1_scan #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int DWELL    = 1
) (
    input logic             clk,
    input logic             reset,
    mux_nto1_scan_if.slave  bus
);
    localparam int SEL_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;

    logic [SEL_W-1:0]    ptr;
    logic [CNT_W-1:0]    cnt;
    logic [WIDTH-1:0]    odata;
    logic [SEL_W-1:0]    ochan;
    logic                ovalid;

    logic [SEL_W-1:0]    ch;
    logic                ch_ok;
    logic                free;
    logic                acc;
    logic [WIDTH-1:0]    word;
    logic                ch_valid;
    logic                ptr_valid;
    logic [CHANNELS-1:0] rdy;
    logic [SEL_W-1:0]    ptr_nxt;
    logic                dwell_last;

    assign ch    = bus.mode ? ptr : bus.sel;
    // sel is wider than needed for non-power-of-two CHANNELS
    assign ch_ok = ({{(32-SEL_W){1'b0}}, ch} < 32'(CHANNELS));
    assign free  = !ovalid || bus.out_ready;

    always_comb begin
        word      = '0;
        ch_valid  = 1'b0;
        ptr_valid = 1'b0;
        rdy       = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (ch == SEL_W'(i)) begin
                word     = bus.in_data[i*WIDTH +: WIDTH];
                ch_valid = bus.in_valid[i];
                rdy[i]   = !reset && bus.enable && free && ch_ok;
            end
            if (ptr == SEL_W'(i)) begin
                ptr_valid = bus.in_valid[i];
            end
        end
    end

    assign acc        = bus.enable && free && ch_ok && ch_valid;
    assign ptr_nxt    = (ptr == SEL_W'(CHANNELS-1)) ? '0 : ptr + 1'b1;
    assign dwell_last = (cnt == CNT_W'(DWELL-1));

    // output register: load on accept, clear on a bare drain
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            odata  <= '0;
            ochan  <= '0;
            ovalid <= 1'b0;
        end else if (acc) begin
            odata  <= word;
            ochan  <= ch;
            ovalid <= 1'b1;
        end else if (bus.out_ready) begin
            ovalid <= 1'b0;
        end
    end

    // scan pointer: dwell on busy channels, skip idle ones one per cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr <= '0;
            cnt <= '0;
        end else if (!bus.mode) begin
            cnt <= '0;
        end else if (bus.enable) begin
            if (acc) begin
                if (dwell_last) begin
                    ptr <= ptr_nxt;
                    cnt <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else if (!ptr_valid) begin
                ptr <= ptr_nxt;
                cnt <= '0;
            end
        end
    end

    assign bus.in_ready  = rdy;
    assign bus.out_data  = odata;
    assign bus.out_chan  = ochan;
    assign bus.out_valid = ovalid;
endmodule
